// File: rtl/bt656_pkg.sv
// Shared types, constants and timing-code helper for the BT656 transmit path.
package bt656_pkg;

  typedef enum logic [2:0] {IDLE, EAV, HBLANK, SAV, ACTIVE} bt656_state_e;

  localparam logic [7:0] BT656_BLANK_Y     = 8'h10;
  localparam logic [7:0] BT656_BLANK_C     = 8'h80;
  localparam logic [7:0] BT656_PREAMBLE_0  = 8'hFF;
  localparam logic [7:0] BT656_PREAMBLE_1  = 8'h00;
  localparam logic [7:0] BT656_PREAMBLE_2  = 8'h00;

  // XY byte: {1,F,V,H,P3,P2,P1,P0} with Hamming protection bits.
  function automatic logic [7:0] bt656_xy(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

endpackage

// File: rtl/bt656_tx_timing.sv
// Line/column counters and slot state machine for the BT656 transmitter.
module bt656_tx_timing
  import bt656_pkg::*;
#(
  parameter int H_ACTIVE    = 1440,
  parameter int H_BLANK     = 268,
  parameter int V_ACTIVE    = 480,
  parameter int V_BLANK_TOP = 20,
  parameter int V_BLANK_BOT = 25,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  output bt656_state_e     state_o,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] line_o,
  output logic             is_blank_line_o,
  output logic             frame_end_o
);

  localparam int LINES = V_BLANK_TOP + V_ACTIVE + V_BLANK_BOT;

  bt656_state_e     state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] line_q, line_d;

  assign frame_end_o = (state_q == ACTIVE) && (col_q == CNT_W'(H_ACTIVE - 1)) &&
                       (line_q == CNT_W'(LINES - 1));
  assign is_blank_line_o = (line_q < CNT_W'(V_BLANK_TOP)) ||
                           (line_q >= CNT_W'(V_BLANK_TOP + V_ACTIVE));

  always_comb begin
    state_d = state_q;
    col_d   = col_q + 1'b1;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        // Column LSB doubles as the idle 0x80/0x10 phase.
        col_d = {{(CNT_W-1){1'b0}}, ~col_q[0]};
        if (enable_i) begin
          state_d = EAV;
          col_d   = '0;
          line_d  = '0;
        end
      end
      EAV: if (col_q == CNT_W'(3)) begin
        state_d = HBLANK;
        col_d   = '0;
      end
      HBLANK: if (col_q == CNT_W'(H_BLANK - 1)) begin
        state_d = SAV;
        col_d   = '0;
      end
      SAV: if (col_q == CNT_W'(3)) begin
        state_d = ACTIVE;
        col_d   = '0;
      end
      ACTIVE: if (col_q == CNT_W'(H_ACTIVE - 1)) begin
        col_d = '0;
        if (line_q == CNT_W'(LINES - 1)) begin
          line_d  = '0;
          state_d = enable_i ? EAV : IDLE;
        end else begin
          line_d  = line_q + 1'b1;
          state_d = EAV;
        end
      end
      default: begin
        state_d = IDLE;
        col_d   = '0;
        line_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
    end
  end

  assign state_o = state_q;
  assign col_o   = col_q;
  assign line_o  = line_q;

endmodule

// File: rtl/axis_bt656_tx.sv
// AXI4-Stream YCbCr 4:2:2 to free-running BT656 byte stream transmitter.
// Optional DVP href/vsync strobes are enabled with macro BT656_TX_DVP_SYNC_EN.
module axis_bt656_tx
  import bt656_pkg::*;
#(
  parameter int H_ACTIVE    = 1440,
  parameter int H_BLANK     = 268,
  parameter int V_ACTIVE    = 480,
  parameter int V_BLANK_TOP = 20,
  parameter int V_BLANK_BOT = 25,
  parameter int CNT_W       = 12
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        enable_i,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [7:0]  bt656_data_o,
  output logic        href_o,
  output logic        vsync_o,
  output logic [15:0] frame_cnt_o,
  output logic        underflow_o,
  output logic        sync_err_o,
  input  logic        clr_i
);

  bt656_state_e     state;
  logic [CNT_W-1:0] col, line;
  logic             blank_line, frame_end;

  bt656_tx_timing #(
    .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
    .V_BLANK_TOP(V_BLANK_TOP), .V_BLANK_BOT(V_BLANK_BOT), .CNT_W(CNT_W)
  ) u_timing (
    .clk(ACLK), .rst_n(ARESETn), .enable_i(enable_i),
    .state_o(state), .col_o(col), .line_o(line),
    .is_blank_line_o(blank_line), .frame_end_o(frame_end)
  );

  logic [7:0]  data_q, data_d;
  logic        tready_q, tready_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        uf_q, uf_d, se_q, se_d;
  logic        href_d, vsync_d;
  logic        accept, last_col, first_col, uf_set, se_set;
  logic [7:0]  black;

  assign accept    = tready_q & s_axis_tvalid;
  assign last_col  = (col == CNT_W'(H_ACTIVE - 1));
  assign first_col = (line == CNT_W'(V_BLANK_TOP)) && (col == '0);
  assign black     = col[0] ? BT656_BLANK_Y : BT656_BLANK_C;

  always_comb begin
    data_d  = black;
    uf_set  = 1'b0;
    se_set  = 1'b0;
    case (state)
      EAV, SAV: begin
        case (col[1:0])
          2'd0:    data_d = BT656_PREAMBLE_0;
          2'd1:    data_d = BT656_PREAMBLE_1;
          2'd2:    data_d = BT656_PREAMBLE_2;
          default: data_d = bt656_xy(1'b0, blank_line, state == EAV);
        endcase
      end
      ACTIVE: begin
        if (accept) begin
          data_d = s_axis_tdata;
          if (s_axis_tuser != first_col) se_set = 1'b1;
          if (last_col != s_axis_tlast)  se_set = 1'b1;
        end else if (tready_q) begin
          uf_set = 1'b1;
        end
      end
      default: data_d = black;
    endcase

    // Ready is registered one slot ahead; an early tlast kills it for the rest of the line.
    tready_d = ((state == SAV) && (col == CNT_W'(3)) && !blank_line) ||
               ((state == ACTIVE) && tready_q && !last_col && !(accept && s_axis_tlast));

    frame_cnt_d = frame_cnt_q + {15'd0, frame_end};
    uf_d        = (uf_q & ~clr_i) | uf_set;
    se_d        = (se_q & ~clr_i) | se_set;
    href_d      = (state == ACTIVE) && !blank_line;
    vsync_d     = (state != IDLE) && (line == '0);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      data_q      <= BT656_BLANK_Y;
      tready_q    <= 1'b0;
      frame_cnt_q <= '0;
      uf_q        <= 1'b0;
      se_q        <= 1'b0;
    end else begin
      data_q      <= data_d;
      tready_q    <= tready_d;
      frame_cnt_q <= frame_cnt_d;
      uf_q        <= uf_d;
      se_q        <= se_d;
    end
  end

`ifdef BT656_TX_DVP_SYNC_EN
  logic href_q, vsync_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      href_q  <= href_d;
      vsync_q <= vsync_d;
    end
  end

  assign href_o  = href_q;
  assign vsync_o = vsync_q;
`else
  logic dvp_unused;
  assign dvp_unused = href_d ^ vsync_d;
  assign href_o  = 1'b0 & dvp_unused;
  assign vsync_o = 1'b0;
`endif

  assign bt656_data_o  = data_q;
  assign s_axis_tready = tready_q;
  assign frame_cnt_o   = frame_cnt_q;
  assign underflow_o   = uf_q;
  assign sync_err_o    = se_q;

endmodule

// File: tb/tb_axis_bt656_tx.sv
// Bench for axis_bt656_tx: frame-position reference model plus directed scenarios.
module tb_axis_bt656_tx;

  localparam int HA = 8, HB = 4, VA = 2, VBT = 1, VBB = 1;
  localparam int LW = 8 + HA + HB;          // 20 bytes per line
  localparam int FL = LW * (VBT + VA + VBB); // 80 slots per frame
`ifdef BT656_TX_DVP_SYNC_EN
  localparam bit DVP = 1'b1;
`else
  localparam bit DVP = 1'b0;
`endif

  logic        clk;
  logic        rst_n = 1'b1;
  logic        enable_i = 1'b0, clr_i = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0, s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
  logic        s_axis_tready, href_o, vsync_o, underflow_o, sync_err_o;
  logic [7:0]  bt656_data_o;
  logic [15:0] frame_cnt_o;

  int total = 0, bad = 0;

  axis_bt656_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK_TOP(VBT), .V_BLANK_BOT(VBB), .CNT_W(12)
  ) dut (
    .ACLK(clk), .ARESETn(rst_n), .enable_i(enable_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .bt656_data_o(bt656_data_o), .href_o(href_o), .vsync_o(vsync_o),
    .frame_cnt_o(frame_cnt_o), .underflow_o(underflow_o), .sync_err_o(sync_err_o), .clr_i(clr_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_pos is the frame slot (line*20+col) consumed at the next edge.
  bit          m_run, m_ph, m_drop;
  int          m_pos;
  logic [7:0]  e_data;
  logic [15:0] e_fc;
  bit          e_uf, e_se, e_href, e_vs;
  bit          k_gap, k_early, k_no_tuser, k_xuser;

  function automatic bit act_line(input int p);
    return (p / LW) >= VBT && (p / LW) < VBT + VA;
  endfunction

  function automatic bit m_ready();
    return m_run && act_line(m_pos) && (m_pos % LW) >= 12 && !m_drop;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int ln, c, a;
    bit blank, rdy, acc, su, ss;
    if (!rst_n) begin
      m_run = 0; m_ph = 0; m_drop = 0; m_pos = 0;
      e_data = 8'h10; e_fc = 0; e_uf = 0; e_se = 0; e_href = 0; e_vs = 0;
    end else begin
      rdy = m_ready();
      acc = rdy && s_axis_tvalid;
      su = 0; ss = 0;
      if (!m_run) begin
        e_data = m_ph ? 8'h10 : 8'h80;
        m_ph = !m_ph;
        e_href = 0; e_vs = 0;
        if (enable_i) begin m_run = 1; m_pos = 0; end
      end else begin
        ln = m_pos / LW; c = m_pos % LW; blank = !act_line(m_pos);
        e_href = !blank && c >= 12;
        e_vs = (ln == 0);
        if (c == 0 || c == 8) e_data = 8'hFF;
        else if (c == 1 || c == 2 || c == 9 || c == 10) e_data = 8'h00;
        else if (c == 3) e_data = blank ? 8'hB6 : 8'h9D;
        else if (c == 11) e_data = blank ? 8'hAB : 8'h80;
        else if (c < 8) e_data = (c % 2 == 0) ? 8'h80 : 8'h10;
        else begin
          a = c - 12;
          if (acc) begin
            e_data = s_axis_tdata;
            if (s_axis_tuser != (ln == VBT && a == 0)) ss = 1;
            if (a == HA - 1 && !s_axis_tlast) ss = 1;
            if (a < HA - 1 && s_axis_tlast) begin ss = 1; m_drop = 1; end
          end else begin
            e_data = (a % 2 == 0) ? 8'h80 : 8'h10;
            if (rdy) su = 1;
          end
        end
        if (m_pos == FL - 1) begin
          e_fc = e_fc + 16'd1;
          if (enable_i) m_pos = 0;
          else begin m_run = 0; m_ph = 0; end
        end else m_pos = m_pos + 1;
        if (m_pos % LW == 0) m_drop = 0;
      end
      e_uf = (e_uf && !clr_i) || su;
      e_se = (e_se && !clr_i) || ss;
    end
  end

  // Source: byte n of active line L carries (L-1)*8+n+1; knobs inject faults.
  always @(posedge clk) begin : driver
    int ln, c, a;
    #2;
    ln = m_pos / LW; c = m_pos % LW;
    if (m_run && act_line(m_pos) && c >= 12) begin
      a = c - 12;
      s_axis_tdata  = 8'((ln - VBT) * HA + a + 1);
      s_axis_tvalid = !(k_gap && a == 3);
      s_axis_tuser  = ((ln == VBT && a == 0) && !k_no_tuser) || (k_xuser && ln == VBT && a == 2);
      s_axis_tlast  = (a == HA - 1) || (k_early && a == 5);
    end else begin
      s_axis_tdata = 8'h00; s_axis_tvalid = 0; s_axis_tuser = 0; s_axis_tlast = 0;
    end
  end

  always @(negedge clk) begin : compare
    chk("data", {8'h00, bt656_data_o}, {8'h00, e_data});
    chk("tready", {15'd0, s_axis_tready}, {15'd0, m_ready()});
    chk("frame_cnt", frame_cnt_o, e_fc);
    chk("underflow", {15'd0, underflow_o}, {15'd0, e_uf});
    chk("sync_err", {15'd0, sync_err_o}, {15'd0, e_se});
    chk("href", {15'd0, href_o}, {15'd0, DVP & e_href});
    chk("vsync", {15'd0, vsync_o}, {15'd0, DVP & e_vs});
  end

  task automatic wait_pos(input int p);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (m_run && m_pos == p) break;
    end
    if (i >= 400) begin
      total++; bad++;
      $display("FAIL wait_pos %0d: timed out, required position not reached", p);
    end
  endtask

  task automatic wait_fc(input logic [15:0] n);
    int i;
    for (i = 0; i < 400; i++) begin
      if (e_fc == n) break;
      @(negedge clk);
    end
    chk("frame_cnt_lit", frame_cnt_o, n);
  endtask

  task automatic clr_pulse();
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    chk("uf_cleared", {15'd0, underflow_o}, 16'd0);
    chk("se_cleared", {15'd0, sync_err_o}, 16'd0);
  endtask

  logic [7:0] lit [40] = '{
    8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
    8'h00, 8'hAB, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10, 8'h80, 8'h10,
    8'hFF, 8'h00, 8'h00, 8'h9D, 8'h80, 8'h10, 8'h80, 8'h10, 8'hFF, 8'h00,
    8'h00, 8'h80, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

  initial begin
    // Reset values and idle pattern
    #1 rst_n = 1'b0;
    #2;
    chk("rst_data", {8'h00, bt656_data_o}, 16'h0010);
    chk("rst_tready", {15'd0, s_axis_tready}, 16'd0);
    chk("rst_fc", frame_cnt_o, 16'd0);
    chk("rst_flags", {14'd0, underflow_o, sync_err_o}, 16'd0);
    @(negedge clk); #3 rst_n = 1'b1;
    @(negedge clk); chk("idle0", {8'h00, bt656_data_o}, 16'h0080);
    @(negedge clk); chk("idle1", {8'h00, bt656_data_o}, 16'h0010);
    @(negedge clk); chk("idle2", {8'h00, bt656_data_o}, 16'h0080);
    chk("idle_tready", {15'd0, s_axis_tready}, 16'd0);

    // Clean frame with literal first two lines
    enable_i = 1'b1;
    wait_pos(1);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("lit%0d", i), {8'h00, bt656_data_o}, {8'h00, lit[i]});
      @(negedge clk);
    end
    wait_fc(16'd1);
    chk("f1_uf", {15'd0, underflow_o}, 16'd0);
    chk("f1_se", {15'd0, sync_err_o}, 16'd0);

    // Missing byte at active column 3
    k_gap = 1;
    wait_pos(LW + 16);
    chk("gap_black", {8'h00, bt656_data_o}, 16'h0010);
    chk("gap_uf", {15'd0, underflow_o}, 16'd1);
    wait_fc(16'd2);
    k_gap = 0;
    clr_pulse();

    // Early tlast on active byte 6
    k_early = 1;
    wait_pos(LW + 18);
    chk("early_tready", {15'd0, s_axis_tready}, 16'd0);
    chk("early_se", {15'd0, sync_err_o}, 16'd1);
    wait_fc(16'd3);
    chk("early_no_uf", {15'd0, underflow_o}, 16'd0);
    k_early = 0;
    clr_pulse();

    // First active byte without tuser
    k_no_tuser = 1;
    wait_pos(LW + 13);
    chk("notuser_byte", {8'h00, bt656_data_o}, 16'h0001);
    chk("notuser_se", {15'd0, sync_err_o}, 16'd1);
    k_no_tuser = 0;
    wait_fc(16'd4);
    clr_pulse();

    // Stray tuser mid-line
    k_xuser = 1;
    wait_fc(16'd5);
    chk("xuser_se", {15'd0, sync_err_o}, 16'd1);
    k_xuser = 0;
    clr_pulse();

    // Disable mid-frame: frame completes, then idle
    wait_pos(40);
    enable_i = 1'b0;
    wait_fc(16'd6);
    @(negedge clk);
    chk("post_idle0", {8'h00, bt656_data_o}, 16'h0080);
    chk("post_tready", {15'd0, s_axis_tready}, 16'd0);
    @(negedge clk);
    chk("post_idle1", {8'h00, bt656_data_o}, 16'h0010);

    // Reset in the middle of a frame
    enable_i = 1'b1;
    wait_pos(50);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_data", {8'h00, bt656_data_o}, 16'h0010);
    chk("midrst_tready", {15'd0, s_axis_tready}, 16'd0);
    chk("midrst_fc", frame_cnt_o, 16'd0);
    enable_i = 1'b0;
    @(negedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {8'h00, bt656_data_o}, 16'h0080);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
